// File: rtl/timer_prog.sv
// Programmable interval timer: prescaled tick source with periodic/one-shot modes,
// start/stop control and a live count readout.
module timer_prog #(
    parameter int BITS     = 8,
    parameter int PRE_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [BITS-1:0]     FINAL_VALUE,
    input  logic [PRE_BITS-1:0] PRESCALE,
    output logic [BITS-1:0]     count,
    output logic                done,
    output logic                running
);

    // state | meaning
    // IDLE  | stopped or one-shot finished; count holds, prescaler frozen
    // RUN   | prescaler advancing, count steps on each tick
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state;
    logic [PRE_BITS-1:0] prescaler;
    logic                mode_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            mode_q    <= 1'b0;
            done      <= 1'b0;
        end else if (!enable) begin
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else if (start) begin
                state     <= RUN;
                count     <= '0;
                prescaler <= '0;
                mode_q    <= mode;
            end else if (state == RUN) begin
                if (prescaler == PRESCALE) begin
                    prescaler <= '0;
                    // >= so a lowered FINAL_VALUE terminates instead of wrapping
                    if (count >= FINAL_VALUE) begin
                        done <= 1'b1;
                        if (mode_q)
                            state <= IDLE;
                        else
                            count <= '0;
                    end else begin
                        count <= count + BITS'(1);
                    end
                end else begin
                    prescaler <= prescaler + PRE_BITS'(1);
                end
            end
        end
    end

    assign running = (state == RUN);

endmodule

// File: doc/timer_prog.md
# timer_prog

Programmable interval timer with a prescaler, periodic and one-shot modes, start/stop control and a live count readout. It is the parametrised successor of the team's fixed-function free-running timer and is the shared tick/timeout source for display multiplexing, debouncing and delay generation. Period, prescale and mode are all runtime inputs, so one instance covers every rate a design needs.

## Interface
- BITS, 8, width of the main counter and FINAL_VALUE
- PRE_BITS, 4, width of the prescaler and PRESCALE

- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  global clock-enable; when low, all state is frozen
- start  input  1  start or restart the timer; level-sampled each enabled edge
- stop  input  1  stop the timer; count holds its value
- mode  input  1  0 = periodic, 1 = one-shot; latched on start
- FINAL_VALUE  input  BITS  terminal count, compared live
- PRESCALE  input  PRE_BITS  tick divider; a tick every PRESCALE+1 enabled cycles
- count  output  BITS  current main counter value
- done  output  1  one-cycle pulse after each terminal tick
- running  output  1  high while in RUN

## Operation
- FSM states: IDLE (reset state), RUN.
- Reset (reset_n low, async): state IDLE, count 0, prescaler 0, latched mode 0, done 0, running 0.
- With enable low, nothing changes (state, count, prescaler, latched mode), and done is driven 0 on the next edge.
- With enable high, the following rules apply, in priority order:
  - stop (any state): go to IDLE, count and prescaler hold. stop wins over a simultaneous start.
  - start (any state): count 0, prescaler 0, latch mode, go to RUN. A start in RUN is a restart.
  - RUN, neither start nor stop asserted: prescaler advances. Tick = (prescaler == PRESCALE). On a tick the prescaler clears to 0; otherwise it increments.
- On a tick in RUN:
  - Terminal condition is count >= FINAL_VALUE. Using >= means lowering FINAL_VALUE below count terminates at the next tick rather than wrapping through 2^BITS.
  - If terminal and periodic: count goes to 0, done goes to 1, and the timer stays in RUN.
  - If terminal and one-shot: count holds, done goes to 1, and the timer goes to IDLE.
  - If not terminal: count increments by 1, modulo 2^BITS. Wrap cannot occur while FINAL_VALUE <= 2^BITS-1.
- done is registered. It is 1 for exactly the cycle after a terminal tick edge and 0 otherwise. With FINAL_VALUE=0, PRESCALE=0 and periodic mode, done stays continuously 1.
- running = (state == RUN).
- Periodic period = (FINAL_VALUE+1)·(PRESCALE+1) enabled cycles.
- PRESCALE and FINAL_VALUE changes take effect from the next edge. No shadow registers.

## Timing
- start sampled at edge E0 → running=1 and count=0 after E0.
- First tick at edge E0+PRESCALE+1, assuming enable stays high.
- First done edge at E0+(FINAL_VALUE+1)(PRESCALE+1). done is visible in the following cycle.
- In one-shot mode, running falls on the same edge that raises done.
- stop at edge E → running=0 after E. done is not generated, even if E would have been terminal.
- Reset asserted mid-run forces all outputs to their reset values immediately, without waiting for a clock. After release, the first enabled edge with start asserted begins a new run.
- Every enable-low cycle stretches the period by exactly one cycle.

## Test plan
- Periodic, BITS=8, FINAL_VALUE=4, PRESCALE=0, start pulse then enable=1 → count sequence 0,1,2,3,4,0…; done pulses every 5 cycles, first on edge E0+5; running stays 1.
- Periodic, FINAL_VALUE=3, PRESCALE=2 → count increments every 3 cycles; done period 12 cycles; enable low for 2 cycles mid-run → that period becomes 14 cycles.
- One-shot, FINAL_VALUE=3, PRESCALE=0 → single done pulse at E0+4; running 1→0 on that edge; count holds 3; no further done; a new start re-runs the sequence identically.
- Control: start and stop in the same cycle during RUN → IDLE with count held. Restart at count=2 → count=0 on the next edge and the full period elapses again. Lower FINAL_VALUE from 9 to 1 while count=5 → done at the next tick and count goes to 0.
- Reset: assert reset_n=0 asynchronously at count=6 in RUN → count=0, done=0, running=0 before the next edge; the block stays in IDLE until a start.
- Edge case: FINAL_VALUE=0, PRESCALE=0, periodic → done held at 1 and count held at 0. Maximum values FINAL_VALUE=255 and PRESCALE=15 → done period 4096 cycles.
